// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the HH:MM:SS clock controller.
//   mode_e      : controller mode encoding (RUN / SET_HOUR / SET_MIN)
//   *_MAX       : last BCD value of each counter before it wraps
//   bcd_at_max  : compare a BCD counter value against its last value
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    function automatic logic bcd_at_max(input logic [7:0] value, input logic [7:0] max_value);
        return (value == max_value);
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_event.sv
// Push-button conditioner: 2-flop synchronizer, rising-edge detector and an
// optional hold/auto-repeat generator.
//   clk, rst : system clock, asynchronous active-high reset
//   btn      : raw asynchronous button level
//   press    : one-cycle press event (edge, or auto-repeat while held)
// The press event is combinational from registers so that the consumer,
// which registers it, acts on the 3rd clock edge after the raw input is
// first sampled high.
module btn_event #(
    parameter bit REPEAT_EN = 1'b0,
    parameter int HOLD_CYC  = 8,
    parameter int REP_CYC   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          prev_r;
    logic [CW-1:0] hold_cnt_r;
    logic          rep_phase_r;
    logic          rise_s;
    logic          rep_fire_s;

    // Synchronizer and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~prev_r;

    // hold_cnt_r equals the number of cycles the synchronized button has been
    // high (0 in the rising-edge cycle) until the first repeat; afterwards it
    // restarts at 1 after every repeat so it fires again REP_CYC cycles later.
    always_comb begin
        rep_fire_s = 1'b0;
        if (REPEAT_EN && sync2_r) begin
            if (!rep_phase_r) begin
                rep_fire_s = (hold_cnt_r == CW'(HOLD_CYC));
            end else begin
                rep_fire_s = (hold_cnt_r == CW'(REP_CYC));
            end
        end else begin
            rep_fire_s = 1'b0;
        end
    end

    // Hold / repeat timer, cleared whenever the button is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r  <= '0;
            rep_phase_r <= 1'b0;
        end else if (!sync2_r) begin
            hold_cnt_r  <= '0;
            rep_phase_r <= 1'b0;
        end else if (rep_fire_s) begin
            hold_cnt_r  <= CW'(1);
            rep_phase_r <= 1'b1;
        end else if (REPEAT_EN) begin
            hold_cnt_r  <= hold_cnt_r + CW'(1);
            rep_phase_r <= rep_phase_r;
        end else begin
            hold_cnt_r  <= '0;
            rep_phase_r <= 1'b0;
        end
    end

    assign press = rise_s | rep_fire_s;

endmodule

// File: rtl/clock_ctrl.sv
// Mode and timing controller for an HH:MM:SS clock built from BCD counters.
//   clk, rst   : system clock, asynchronous active-high reset
//   btn_mode   : raw mode button (RUN -> SET_HOUR -> SET_MIN -> RUN)
//   btn_inc    : raw increment button (auto-repeats while held)
//   sec_cnt    : BCD seconds from the seconds counter
//   min_cnt    : BCD minutes from the minutes counter
//   cnt_en     : enable to all counters (always 1)
//   sec_step   : one-cycle carry-in to the seconds counter
//   min_step   : one-cycle carry-in to the minutes counter
//   hour_step  : one-cycle carry-in to the hours counter
//   sec_clr    : one-cycle clear of the seconds counter on return to RUN
//   mode       : current mode
//   blink      : display gate for the field being set
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int HOLD_CYC = 50000000,
    parameter int REP_CYC  = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] sec_cnt,
    input  logic [7:0] min_cnt,
    output logic       cnt_en,
    output logic       sec_step,
    output logic       min_step,
    output logic       hour_step,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int HALF = TICK_DIV / 2;
    localparam int BW   = $clog2(HALF + 1);

    mode_e         mode_r,  mode_n;
    logic [PW-1:0] presc_r, presc_n;
    logic [BW-1:0] blk_r,   blk_n;
    logic          blink_r, blink_n;
    logic          sec_r,   sec_n;
    logic          min_r,   min_n;
    logic          hour_r,  hour_n;
    logic          clr_r,   clr_n;
    logic          en_r;
    logic          mode_evt_s;
    logic          inc_evt_s;
    logic          tick_s;
    logic          blk_wrap_s;

    btn_event #(
        .REPEAT_EN (1'b0),
        .HOLD_CYC  (HOLD_CYC),
        .REP_CYC   (REP_CYC)
    ) u_btn_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (mode_evt_s)
    );

    btn_event #(
        .REPEAT_EN (1'b1),
        .HOLD_CYC  (HOLD_CYC),
        .REP_CYC   (REP_CYC)
    ) u_btn_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .press (inc_evt_s)
    );

    assign tick_s     = (presc_r == PW'(TICK_DIV - 1));
    assign blk_wrap_s = (blk_r == BW'(HALF - 1));

    // Mode FSM next state, prescaler, blink divider and step pulses.
    // A mode event always wins: the coincident tick or inc event is dropped.
    always_comb begin
        mode_n  = mode_r;
        presc_n = presc_r;
        blk_n   = blk_r;
        blink_n = blink_r;
        sec_n   = 1'b0;
        min_n   = 1'b0;
        hour_n  = 1'b0;
        clr_n   = 1'b0;
        case (mode_r)
            MODE_RUN: begin
                blink_n = 1'b1;
                if (mode_evt_s) begin
                    mode_n  = MODE_SET_HOUR;
                    presc_n = '0;
                    blk_n   = '0;
                end else if (tick_s) begin
                    presc_n = '0;
                    sec_n   = 1'b1;
                    min_n   = bcd_at_max(sec_cnt, SEC_MAX);
                    hour_n  = bcd_at_max(sec_cnt, SEC_MAX) & bcd_at_max(min_cnt, MIN_MAX);
                end else begin
                    presc_n = presc_r + PW'(1);
                end
            end
            MODE_SET_HOUR, MODE_SET_MIN: begin
                presc_n = '0;
                if (mode_evt_s) begin
                    blink_n = 1'b1;
                    blk_n   = '0;
                    if (mode_r == MODE_SET_HOUR) begin
                        mode_n = MODE_SET_MIN;
                    end else begin
                        mode_n = MODE_RUN;
                        clr_n  = 1'b1;
                    end
                end else begin
                    if (blk_wrap_s) begin
                        blink_n = ~blink_r;
                        blk_n   = '0;
                    end else begin
                        blk_n = blk_r + BW'(1);
                    end
                    if (mode_r == MODE_SET_HOUR) begin
                        hour_n = inc_evt_s;
                    end else begin
                        min_n = inc_evt_s;
                    end
                end
            end
            default: begin
                mode_n  = MODE_RUN;
                presc_n = '0;
                blk_n   = '0;
                blink_n = 1'b1;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r  <= MODE_RUN;
            presc_r <= '0;
            blk_r   <= '0;
            blink_r <= 1'b1;
            sec_r   <= 1'b0;
            min_r   <= 1'b0;
            hour_r  <= 1'b0;
            clr_r   <= 1'b0;
            en_r    <= 1'b1;
        end else begin
            mode_r  <= mode_n;
            presc_r <= presc_n;
            blk_r   <= blk_n;
            blink_r <= blink_n;
            sec_r   <= sec_n;
            min_r   <= min_n;
            hour_r  <= hour_n;
            clr_r   <= clr_n;
            en_r    <= 1'b1;
        end
    end

    assign cnt_en    = en_r;
    assign sec_step  = sec_r;
    assign min_step  = min_r;
    assign hour_step = hour_r;
    assign sec_clr   = clr_r;
    assign mode      = mode_r;
    assign blink     = blink_r;

endmodule

// File: tb/tb_clock_ctrl.sv
module tb_clock_ctrl;

    localparam int TD = 4;
    localparam int HC = 8;
    localparam int RC = 4;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] sec_cnt;
    logic [7:0] min_cnt;
    logic       cnt_en;
    logic       sec_step;
    logic       min_step;
    logic       hour_step;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    int total = 0;
    int bad   = 0;

    // Reference model state: raw button history since reset, mode, and
    // elapsed-cycle counters from which tick and blink are derived.
    bit hm [0:8191];
    bit hi [0:8191];
    int ecnt;
    int m_mode;
    int runn;
    int setn;
    logic       e_sec, e_min, e_hour, e_clr, e_blink;
    logic [1:0] e_mode;

    clock_ctrl #(
        .TICK_DIV (TD),
        .HOLD_CYC (HC),
        .REP_CYC  (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_cnt   (sec_cnt),
        .min_cnt   (min_cnt),
        .cnt_en    (cnt_en),
        .sec_step  (sec_step),
        .min_step  (min_step),
        .hour_step (hour_step),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit raw_at(bit is_inc, int idx);
        if (idx < 1) return 1'b0;
        return is_inc ? hi[idx] : hm[idx];
    endfunction

    // Press event consumed at the current edge: decided by the raw level seen
    // two edges earlier and how long it had been continuously high then.
    function automatic bit press_now(bit is_inc);
        int idx;
        int len;
        int k;
        idx = ecnt - 2;
        if (!raw_at(is_inc, idx)) return 1'b0;
        len = 0;
        for (int j = idx; j >= 1 && raw_at(is_inc, j); j--) len++;
        k = len - 1;
        if (k == 0) return 1'b1;
        if (!is_inc) return 1'b0;
        return (k >= HC) && (((k - HC) % RC) == 0);
    endfunction

    task automatic model_reset();
        ecnt    = 0;
        m_mode  = 0;
        runn    = 0;
        setn    = 0;
        e_sec   = 1'b0;
        e_min   = 1'b0;
        e_hour  = 1'b0;
        e_clr   = 1'b0;
        e_blink = 1'b1;
        e_mode  = 2'd0;
    endtask

    task automatic model_edge();
        bit mev;
        bit iev;
        ecnt++;
        hm[ecnt] = btn_mode;
        hi[ecnt] = btn_inc;
        mev = press_now(1'b0);
        iev = press_now(1'b1);
        e_sec  = 1'b0;
        e_min  = 1'b0;
        e_hour = 1'b0;
        e_clr  = 1'b0;
        if (m_mode == 0) begin
            e_blink = 1'b1;
            if (mev) begin
                m_mode = 1;
                setn   = 0;
            end else begin
                runn++;
                if ((runn % TD) == 0) begin
                    e_sec  = 1'b1;
                    e_min  = (sec_cnt == 8'h59);
                    e_hour = (sec_cnt == 8'h59) && (min_cnt == 8'h59);
                end
            end
        end else if (mev) begin
            e_blink = 1'b1;
            setn    = 0;
            if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0;
                runn   = 0;
                e_clr  = 1'b1;
            end
        end else begin
            setn++;
            e_blink = (((setn / (TD / 2)) % 2) == 0);
            if (m_mode == 1) e_hour = iev;
            else             e_min  = iev;
        end
        e_mode = 2'(m_mode);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("cnt_en",    {7'd0, cnt_en},    8'd1);
        chk("sec_step",  {7'd0, sec_step},  {7'd0, e_sec});
        chk("min_step",  {7'd0, min_step},  {7'd0, e_min});
        chk("hour_step", {7'd0, hour_step}, {7'd0, e_hour});
        chk("sec_clr",   {7'd0, sec_clr},   {7'd0, e_clr});
        chk("mode",      {6'd0, mode},      {6'd0, e_mode});
        chk("blink",     {7'd0, blink},     {7'd0, e_blink});
    endtask

    task automatic check_reset_vals();
        model_reset();
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic press_mode(input int len, input int gap);
        btn_mode = 1'b1;
        run(len);
        btn_mode = 1'b0;
        run(gap);
    endtask

    task automatic press_inc(input int len, input int gap);
        btn_inc = 1'b1;
        run(len);
        btn_inc = 1'b0;
        run(gap);
    endtask

    function automatic logic [7:0] pick_bcd();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return 8'h59;
        if (sel == 1) return 8'h12;
        return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        sec_cnt  = 8'h00;
        min_cnt  = 8'h00;
        #3;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Free run: sec_step at cycles 4, 8, 12.
        run(12);

        // Cascade into minutes and hours, then minutes only.
        sec_cnt = 8'h59;
        min_cnt = 8'h59;
        run(8);
        min_cnt = 8'h12;
        run(8);
        sec_cnt = 8'h30;

        // Inc ignored in RUN.
        press_inc(3, 6);

        // Mode walk with inc presses in each SET state.
        press_mode(2, 6);
        press_inc(2, 8);
        press_mode(2, 6);
        min_cnt = 8'h59;
        press_inc(2, 8);

        // Hold inc for 30 cycles in SET_MIN: auto-repeat.
        press_inc(30, 8);

        // Back to RUN: sec_clr, then sec_step 4 cycles later.
        press_mode(2, 10);

        // Simultaneous mode and inc in SET_HOUR.
        press_mode(2, 6);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        run(2);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        run(6);

        // Reset asserted in the middle of an inc hold.
        btn_inc = 1'b1;
        run(15);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(6);
        btn_inc = 1'b0;
        run(6);

        // Randomized button and counter activity.
        for (int s = 0; s < 150; s++) begin
            int act;
            sec_cnt = pick_bcd();
            min_cnt = pick_bcd();
            act = $urandom_range(0, 4);
            case (act)
                0: press_mode($urandom_range(1, 4), $urandom_range(0, 6));
                1: press_inc($urandom_range(1, 30), $urandom_range(0, 6));
                2: begin
                    btn_mode = 1'b1;
                    btn_inc  = 1'b1;
                    run($urandom_range(1, 3));
                    btn_mode = 1'b0;
                    run($urandom_range(0, 12));
                    btn_inc  = 1'b0;
                    run($urandom_range(0, 5));
                end
                default: run($urandom_range(1, 10));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
